// File: rtl/inst_fetch_if.sv
// Shared types and the instruction-memory request/response bus used by inst_fetch.
package inst_fetch_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    JUMP     = 2'd1,
    TRAP     = 2'd2
  } nextPCType_e;
endpackage

interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem request, single-entry instruction buffer
// toward IF_ID, and redirect handling that drops stale responses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  nextPCType_e      pc_sel,
  input  logic [XLEN-1:0]  jump_addr,
  input  logic [XLEN-1:0]  trap_addr,
  input  logic             inst_rd_en,
  input  logic             if_id_clk_en,
  inst_fetch_if.master     imem,
  output logic             inst_ready,
  output logic [XLEN-1:0]  inst_out,
  output logic [XLEN-1:0]  pc_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
  logic [XLEN-1:0] inst_d, pc_out_d;
  logic            ready_d;
  logic            redirect;
  logic            issue;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_aligned;

  assign pc_aligned = {pc_q[XLEN-1:2], 2'b00};

  // Redirect decode; targets are forced word-aligned.
  always_comb begin
    redirect = 1'b0;
    target   = pc_q;
    case (pc_sel)
      JUMP: begin
        redirect = 1'b1;
        target   = {jump_addr[XLEN-1:2], 2'b00};
      end
      TRAP: begin
        redirect = 1'b1;
        target   = {trap_addr[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Next-state and buffer update logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_fetch_d = pc_fetch_q;
    ready_d    = inst_ready;
    inst_d     = inst_out;
    pc_out_d   = pc_out;
    issue      = inst_rd_en && !redirect &&
                 ((state_q == S_IDLE) || ((state_q == S_HOLD) && if_id_clk_en));

    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_d = imem.rvalid ? S_IDLE : S_DROP;
        end else if (imem.rvalid) begin
          state_d  = S_HOLD;
          ready_d  = 1'b1;
          inst_d   = imem.rdata;
          pc_out_d = pc_fetch_q;
          pc_d     = pc_fetch_q + XLEN'(4);
        end
      end
      S_DROP: begin
        if (imem.rvalid) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (redirect || if_id_clk_en) begin
          ready_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = issue ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue)    pc_fetch_d = pc_aligned;
    if (redirect) pc_d       = target;
  end

  assign imem.req  = clk_en && !rst && issue;
  assign imem.addr = pc_aligned;

  // State register; reset wins over clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_fetch_q <= RESET_PC;
      inst_ready <= 1'b0;
      inst_out   <= NOP_INST;
      pc_out     <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_fetch_q <= pc_fetch_d;
      inst_ready <= ready_d;
      inst_out   <= inst_d;
      pc_out     <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// against a transaction-level fetch model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, clk_en, inst_rd_en, if_id_clk_en;
  nextPCType_e pc_sel;
  logic [31:0] jump_addr, trap_addr;
  logic        inst_ready;
  logic [31:0] inst_out, pc_out;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch_if imem ();

  inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .pc_sel       (pc_sel),
    .jump_addr    (jump_addr),
    .trap_addr    (trap_addr),
    .inst_rd_en   (inst_rd_en),
    .if_id_clk_en (if_id_clk_en),
    .imem         (imem),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  task automatic dflt();
    rst = 1'b0; clk_en = 1'b1; inst_rd_en = 1'b1; if_id_clk_en = 1'b0;
    pc_sel = PC_PLUS4; jump_addr = '0; trap_addr = '0;
    imem.rvalid = 1'b0; imem.rdata = '0;
  endtask

  // Advance to the next cycle's input-drive point with quiet defaults.
  task automatic cyc();
    @(negedge clk);
    dflt();
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1; #1;
  endtask

  task automatic test_reset();
    cyc(); rst = 1'b1; #1;
    n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", imem.req); end
    cyc(); #1;
    n_chk++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0b want 0", inst_ready); end
    n_chk++; if (inst_out !== NOP) begin n_fail++; $display("FAIL rst_inst got %h want %h", inst_out, NOP); end
    n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc_out got %h want 0", pc_out); end
    n_chk++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin n_fail++; $display("FAIL first_req got %0b/%h want 1/0", imem.req, imem.addr); end
    cyc(); imem.rvalid = 1'b1; imem.rdata = 32'h00A0_0093; #1;
    n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL wait_req got %0b want 0", imem.req); end
    cyc(); #1;
    n_chk++; if (inst_ready !== 1'b1 || inst_out !== 32'h00A0_0093 || pc_out !== 32'h0) begin
      n_fail++; $display("FAIL first_inst got %0b/%h/%h want 1/00a00093/0", inst_ready, inst_out, pc_out); end
    for (int i = 0; i < 5; i++) begin
      cyc(); imem.rvalid = 1'(i % 2); imem.rdata = $urandom; #1;
      n_chk++; if (inst_ready !== 1'b1 || inst_out !== 32'h00A0_0093 || pc_out !== 32'h0 || imem.req !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable[%0d] got %0b/%h/%h req %0b", i, inst_ready, inst_out, pc_out, imem.req); end
    end
    cyc(); if_id_clk_en = 1'b1; #1;
    n_chk++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin n_fail++; $display("FAIL consume_req got %0b/%h want 1/4", imem.req, imem.addr); end
    cyc(); #1;
    n_chk++; if (inst_ready !== 1'b0 || inst_out !== NOP) begin n_fail++; $display("FAIL consumed got %0b/%h want 0/nop", inst_ready, inst_out); end
  endtask

  task automatic test_jump_drop();
    do_reset();
    cyc(); #1;
    cyc(); pc_sel = JUMP; jump_addr = 32'h100; #1;
    n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL jump_req got %0b want 0", imem.req); end
    cyc(); #1;
    cyc(); imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF; #1;
    n_chk++; if (imem.req !== 1'b0 || inst_ready !== 1'b0) begin n_fail++; $display("FAIL drop_state got %0b/%0b want 0/0", imem.req, inst_ready); end
    cyc(); #1;
    n_chk++; if (inst_ready !== 1'b0 || inst_out !== NOP) begin n_fail++; $display("FAIL stale_shown got %0b/%h want 0/nop", inst_ready, inst_out); end
    n_chk++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin n_fail++; $display("FAIL jump_fetch got %0b/%h want 1/100", imem.req, imem.addr); end
    cyc(); imem.rvalid = 1'b1; imem.rdata = 32'h1234_5678; #1;
    cyc(); #1;
    n_chk++; if (inst_out !== 32'h1234_5678 || pc_out !== 32'h100) begin n_fail++; $display("FAIL jump_inst got %h/%h want 12345678/100", inst_out, pc_out); end
  endtask

  task automatic test_trap_same_cycle();
    do_reset();
    cyc(); #1;
    cyc(); imem.rvalid = 1'b1; imem.rdata = 32'hCAFE_0001; pc_sel = TRAP; trap_addr = 32'h3E8; #1;
    n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL trap_req got %0b want 0", imem.req); end
    cyc(); #1;
    n_chk++; if (inst_ready !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h3E8) begin
      n_fail++; $display("FAIL trap_fetch got %0b/%0b/%h want 0/1/3e8", inst_ready, imem.req, imem.addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(); pc_sel = JUMP; jump_addr = 32'hFFFF_FFFF; #1;
    n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_req got %0b want 0", imem.req); end
    cyc(); #1;
    n_chk++; if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL top_fetch got %0b/%h want 1/fffffffc", imem.req, imem.addr); end
    cyc(); imem.rvalid = 1'b1; imem.rdata = 32'h0000_0055; #1;
    cyc(); if_id_clk_en = 1'b1; #1;
    n_chk++; if (pc_out !== 32'hFFFF_FFFC || imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap got pc_out %h req %0b addr %h want fffffffc/1/0", pc_out, imem.req, imem.addr); end
  endtask

  task automatic test_clk_en();
    do_reset();
    cyc(); #1;
    for (int i = 0; i < 3; i++) begin
      cyc(); clk_en = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_0000 | 32'(i); #1;
      n_chk++; if (imem.req !== 1'b0 || inst_ready !== 1'b0) begin n_fail++; $display("FAIL gated[%0d] got %0b/%0b want 0/0", i, imem.req, inst_ready); end
    end
    cyc(); #1;
    n_chk++; if (imem.req !== 1'b0 || inst_ready !== 1'b0) begin n_fail++; $display("FAIL still_wait got %0b/%0b want 0/0", imem.req, inst_ready); end
    cyc(); imem.rvalid = 1'b1; imem.rdata = 32'h0000_0513; #1;
    cyc(); clk_en = 1'b0; if_id_clk_en = 1'b1; #1;
    n_chk++; if (inst_ready !== 1'b1 || inst_out !== 32'h0000_0513 || imem.req !== 1'b0) begin
      n_fail++; $display("FAIL gated_hold got %0b/%h req %0b want 1/00000513/0", inst_ready, inst_out, imem.req); end
    cyc(); clk_en = 1'b0; rst = 1'b1; #1;
    cyc(); #1;
    n_chk++; if (inst_ready !== 1'b0 || inst_out !== NOP || pc_out !== 32'h0 || imem.req !== 1'b1 || imem.addr !== RESET_PC) begin
      n_fail++; $display("FAIL gated_reset got %0b/%h/%h req %0b addr %h", inst_ready, inst_out, pc_out, imem.req, imem.addr); end
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    cyc(); #1;
    cyc(); rst = 1'b1; #1;
    cyc(); inst_rd_en = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h00BA_DBAD; #1;
    n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL late_rsp_req got %0b want 0", imem.req); end
    cyc(); inst_rd_en = 1'b0; #1;
    n_chk++; if (inst_ready !== 1'b0 || inst_out !== NOP) begin n_fail++; $display("FAIL late_rsp got %0b/%h want 0/nop", inst_ready, inst_out); end
    cyc(); #1;
    n_chk++; if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin n_fail++; $display("FAIL after_late got %0b/%h want 1/0", imem.req, imem.addr); end
  endtask

  // Model: pc, one optional outstanding fetch (live or stale), one optional buffered instruction.
  task automatic test_random(input int n);
    logic [31:0] m_pc, m_fpc, m_bpc, m_binst, tgt, mem_data;
    logic        pend, live, hbuf, redir, e_req;
    int          mem_cnt, r;
    m_pc = RESET_PC; m_fpc = '0; m_bpc = '0; m_binst = NOP; mem_data = '0;
    pend = 1'b0; live = 1'b0; hbuf = 1'b0; mem_cnt = 0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 63) == 0);
      clk_en       = ($urandom_range(0, 7) != 0);
      inst_rd_en   = ($urandom_range(0, 3) != 0);
      if_id_clk_en = 1'($urandom_range(0, 1));
      r            = int'($urandom_range(0, 11));
      pc_sel       = (r == 0) ? JUMP : ((r == 1) ? TRAP : PC_PLUS4);
      jump_addr    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      trap_addr    = $urandom;
      imem.rvalid  = 1'b0;
      imem.rdata   = $urandom;
      if (clk_en && mem_cnt == 1) begin
        imem.rvalid = 1'b1; imem.rdata = mem_data; mem_cnt = 0;
      end else if (clk_en && mem_cnt > 1) begin
        mem_cnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        imem.rvalid = 1'b1;
      end
      if (rst) mem_cnt = 0;

      redir = (pc_sel != PC_PLUS4);
      tgt   = ((pc_sel == JUMP) ? jump_addr : trap_addr) & ~32'd3;
      e_req = !rst && clk_en && inst_rd_en && !redir && !pend && (!hbuf || if_id_clk_en);
      #1;
      n_chk++; if (imem.req !== e_req) begin n_fail++; $display("FAIL rnd_req[%0d] got %0b want %0b", i, imem.req, e_req); end
      if (e_req) begin
        n_chk++; if (imem.addr !== (m_pc & ~32'd3)) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem.addr, m_pc & ~32'd3); end
      end
      n_chk++; if (inst_ready !== hbuf || inst_out !== (hbuf ? m_binst : NOP)) begin
        n_fail++; $display("FAIL rnd_inst[%0d] got %0b/%h want %0b/%h", i, inst_ready, inst_out, hbuf, hbuf ? m_binst : NOP); end
      if (hbuf) begin
        n_chk++; if (pc_out !== m_bpc) begin n_fail++; $display("FAIL rnd_pc_out[%0d] got %h want %h", i, pc_out, m_bpc); end
      end

      if (rst) begin
        m_pc = RESET_PC; pend = 1'b0; hbuf = 1'b0;
      end else if (clk_en) begin
        if (pend && imem.rvalid) begin
          pend = 1'b0;
          if (live && !redir) begin
            hbuf = 1'b1; m_binst = imem.rdata; m_bpc = m_fpc; m_pc = m_fpc + 32'd4;
          end
        end else if (pend && redir) begin
          live = 1'b0;
        end else if (!pend && hbuf && (redir || if_id_clk_en)) begin
          hbuf = 1'b0;
        end
        if (e_req) begin
          pend = 1'b1; live = 1'b1; m_fpc = m_pc & ~32'd3;
          mem_cnt = int'($urandom_range(1, 3)); mem_data = $urandom;
        end
        if (redir) m_pc = tgt;
      end
    end
  endtask

  initial begin
    dflt();
    rst = 1'b1;
    test_reset();
    test_jump_drop();
    test_trap_same_cycle();
    test_wrap();
    test_clk_en();
    test_reset_outstanding();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
